// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with word-by-word refill.
// Optional hit/miss statistics counters are built when CACHE_STATS_EN is defined.
module dm_cache_ctrl #(
   parameter int ADDR_W  = 12,
   parameter int INDEX_W = 4,
   parameter int OFF_W   = 2,
   parameter int DATA_W  = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_wdata_i,
   output logic [DATA_W-1:0] cpu_rdata_o,
   output logic              cpu_ready_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ack_i
`ifdef CACHE_STATS_EN
   ,
   output logic [15:0]       hit_cnt_o,
   output logic [15:0]       miss_cnt_o
`endif
);

   localparam int TAG_W = ADDR_W - INDEX_W - OFF_W;
   localparam int LINES = 1 << INDEX_W;
   localparam int WORDS = 1 << OFF_W;

   typedef enum logic [1:0] {LOOKUP, REFILL, WRITE} state_t;

   state_t               state_q, state_d;
   logic [OFF_W-1:0]     cnt_q, cnt_d;
   logic [LINES-1:0]     valid_q;
   logic [TAG_W-1:0]     tag_mem_q  [LINES];
   logic [DATA_W-1:0]    data_mem_q [LINES*WORDS];
   logic [TAG_W-1:0]     rtag_q;
   logic [INDEX_W-1:0]   ridx_q;

   logic [TAG_W-1:0]     cpu_tag;
   logic [INDEX_W-1:0]   cpu_idx;
   logic [OFF_W-1:0]     cpu_off;
   logic                 hit;
   logic                 load_hit;
   logic                 refill_start;
   logic                 refill_wr;
   logic                 refill_done;
   logic                 store_wr;

   assign cpu_tag = cpu_addr_i[ADDR_W-1:INDEX_W+OFF_W];
   assign cpu_idx = cpu_addr_i[INDEX_W+OFF_W-1:OFF_W];
   assign cpu_off = cpu_addr_i[OFF_W-1:0];
   assign hit     = valid_q[cpu_idx] && (tag_mem_q[cpu_idx] == cpu_tag);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      cpu_ready_o  = 1'b0;
      cpu_rdata_o  = '0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = '0;
      mem_wdata_o  = '0;
      load_hit     = 1'b0;
      refill_start = 1'b0;
      refill_wr    = 1'b0;
      refill_done  = 1'b0;
      store_wr     = 1'b0;
      case (state_q)
         LOOKUP: begin
            if (cpu_req_i) begin
               if (cpu_we_i) begin
                  state_d = WRITE;
               end else if (hit) begin
                  load_hit    = 1'b1;
                  cpu_ready_o = 1'b1;
                  cpu_rdata_o = data_mem_q[{cpu_idx, cpu_off}];
               end else begin
                  refill_start = 1'b1;
                  cnt_d        = '0;
                  state_d      = REFILL;
               end
            end
         end
         // Refill address comes from the tag/index latched at miss entry, so a CPU
         // that drops its request mid-refill cannot redirect the remaining words.
         REFILL: begin
            mem_req_o  = 1'b1;
            mem_addr_o = {rtag_q, ridx_q, cnt_q};
            if (mem_ack_i) begin
               refill_wr = 1'b1;
               cnt_d     = cnt_q + 1'b1;
               if (cnt_q == {OFF_W{1'b1}}) begin
                  refill_done = 1'b1;
                  state_d     = LOOKUP;
               end
            end
         end
         WRITE: begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = cpu_addr_i;
            mem_wdata_o = cpu_wdata_i;
            if (mem_ack_i) begin
               cpu_ready_o = 1'b1;
               store_wr    = hit;
               state_d     = LOOKUP;
            end
         end
         default: state_d = LOOKUP;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= LOOKUP;
         cnt_q   <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (refill_start) begin
            valid_q[cpu_idx] <= 1'b0;
            rtag_q           <= cpu_tag;
            ridx_q           <= cpu_idx;
         end
         if (refill_done) begin
            valid_q[ridx_q]   <= 1'b1;
            tag_mem_q[ridx_q] <= rtag_q;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (refill_wr) begin
            data_mem_q[{ridx_q, cnt_q}] <= mem_rdata_i;
         end else if (store_wr) begin
            data_mem_q[{cpu_idx, cpu_off}] <= cpu_wdata_i;
         end
      end
   end

`ifdef CACHE_STATS_EN
   logic [15:0] hit_cnt_q, miss_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (load_hit && (hit_cnt_q != 16'hFFFF))
            hit_cnt_q <= hit_cnt_q + 16'd1;
         if (refill_start && (miss_cnt_q != 16'hFFFF))
            miss_cnt_q <= miss_cnt_q + 16'd1;
      end
   end

   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
